// File: rtl/xadac_exe_router_pkg.sv
// Shared types for the xadac execute router.
// Request/response bundles and the route tag.
package xadac_exe_router_pkg;

    localparam int NoMstMax = 8;
    localparam int IdW      = 4;

    typedef logic [IdW-1:0] IdT;

    typedef logic [$clog2(NoMstMax+1)-1:0] RouteT;

    localparam RouteT ROUTE_LOCAL = '1;

    typedef struct packed {
        IdT          id;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } ReqT;

    typedef struct packed {
        IdT          id;
        logic        rd_write;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        vd_write;
        logic [4:0]  vd_addr;
        logic [63:0] vd_data;
    } RspT;

    typedef struct packed {
        RouteT dst;
        IdT    id;
    } RouteTagT;

endpackage

// File: rtl/xadac_exe_router_if.sv
// xadac execute channel: request and response
// valid/ready handshakes in one bundle.
interface xadac_exe_router_if;
    import xadac_exe_router_pkg::*;

    ReqT  req;
    logic req_valid;
    logic req_ready;
    RspT  rsp;
    logic rsp_valid;
    logic rsp_ready;

    modport slv (
        input  req,
        input  req_valid,
        output req_ready,
        output rsp,
        output rsp_valid,
        input  rsp_ready
    );

    modport mst (
        output req,
        output req_valid,
        input  req_ready,
        input  rsp,
        input  rsp_valid,
        output rsp_ready
    );

endinterface

// File: rtl/xadac_exe_router_tag_fifo.sv
// Outstanding-request tag FIFO.
// Wrapping pointers plus a count for full/empty.
module xadac_exe_router_tag_fifo #(
    parameter int  Depth = 4,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

    T                mem [Depth];
    logic [PtrW-1:0] wptr;
    logic [PtrW-1:0] rptr;
    logic [PtrW:0]   count;
    logic            do_push;
    logic            do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FullCnt);
    assign empty   = (count == '0);
    assign head    = mem[rptr];

    // Advance pointers and track occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Tag storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/xadac_exe_router.sv
// Opcode-routed fan-out of one xadac execute
// channel with in-order response return.
module xadac_exe_router
    import xadac_exe_router_pkg::*;
#(
    parameter int NoMst = 2,
    parameter int Depth = 4,
    parameter logic [NoMst-1:0][6:0] OpcodeMap = {7'h2B, 7'h0B}
) (
    input logic             clk_i,
    input logic             rst_i,
    xadac_exe_router_if.slv slv,
    xadac_exe_router_if.mst mst [NoMst]
);

    if (NoMst < 1 || NoMst > NoMstMax) begin : g_bad_nomst
        $error("xadac_exe_router: NoMst out of range");
    end

    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
        $error("xadac_exe_router: Depth must be a power of 2");
    end

    for (genvar i = 0; i < NoMst; i++) begin : g_uniq_i
        for (genvar j = i + 1; j < NoMst; j++) begin : g_uniq_j
            if (OpcodeMap[i] == OpcodeMap[j]) begin : g_dup
                $error("xadac_exe_router: duplicate OpcodeMap");
            end
        end
    end

    RouteT            dst;
    RouteTagT         push_tag;
    RouteTagT         head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             req_go;
    logic             sel_ready;
    logic             head_local;
    logic [NoMst-1:0] req_sel;
    logic [NoMst-1:0] head_sel;
    logic [NoMst-1:0] unit_req_ready;
    logic [NoMst-1:0] unit_rsp_valid;
    RspT              unit_rsp [NoMst];
    RspT              slv_rsp;

    // Lowest matching unit wins; no match answers locally.
    always_comb begin
        dst = ROUTE_LOCAL;
        for (int k = NoMst - 1; k >= 0; k--) begin
            if (slv.req.instr[6:0] == OpcodeMap[k]) dst = RouteT'(k);
        end
    end

    assign req_go    = ~rst_i & slv.req_valid & ~full;
    assign sel_ready = (dst == ROUTE_LOCAL) |
                       (|(req_sel & unit_req_ready));

    assign slv.req_ready = ~rst_i & ~full & sel_ready;

    assign push        = slv.req_valid & slv.req_ready;
    assign push_tag.dst = dst;
    assign push_tag.id  = slv.req.id;

    assign head_local = ~empty & (head.dst == ROUTE_LOCAL);

    assign slv.rsp_valid = ~rst_i & ~empty &
                           (head_local | (|(head_sel & unit_rsp_valid)));

    assign pop = slv.rsp_valid & slv.rsp_ready;

    // Head unit's response, or a null reply for local tags.
    always_comb begin
        slv_rsp    = '0;
        slv_rsp.id = head.id;
        for (int k = 0; k < NoMst; k++) begin
            if (head_sel[k]) slv_rsp = unit_rsp[k];
        end
    end

    assign slv.rsp = slv_rsp;

    for (genvar k = 0; k < NoMst; k++) begin : g_unit
        assign req_sel[k]  = (dst == RouteT'(k));
        assign head_sel[k] = ~empty & (head.dst == RouteT'(k));

        assign mst[k].req       = slv.req;
        assign mst[k].req_valid = req_go & req_sel[k];
        assign mst[k].rsp_ready = ~rst_i & head_sel[k] & slv.rsp_ready;

        assign unit_req_ready[k] = mst[k].req_ready;
        assign unit_rsp_valid[k] = mst[k].rsp_valid;
        assign unit_rsp[k]       = mst[k].rsp;

        a_rsp_id: assert property (
            @(posedge clk_i) disable iff (rst_i)
            (head_sel[k] & unit_rsp_valid[k] & slv.rsp_ready)
            |-> (unit_rsp[k].id == head.id)
        );
    end

    a_req_stable: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (slv.req_valid & ~slv.req_ready) |=> slv.req_valid
    );

    xadac_exe_router_tag_fifo #(
        .Depth (Depth),
        .T     (RouteTagT)
    ) u_tag_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (push_tag),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_xadac_exe_router.sv
// Bench for xadac_exe_router: queue model checked
// every cycle plus directed literal expectations.
module tb_xadac_exe_router;
    import xadac_exe_router_pkg::*;

    localparam int NoMst = 2;
    localparam int Depth = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    xadac_exe_router_if slv_if ();
    xadac_exe_router_if mst_if [NoMst] ();

    logic             u_req_ready [NoMst];
    logic             u_rsp_valid [NoMst];
    RspT              u_rsp [NoMst];
    logic [NoMst-1:0] m_req_valid;
    logic [NoMst-1:0] m_rsp_ready;
    IdT               m_req_id [NoMst];

    for (genvar k = 0; k < NoMst; k++) begin : g_u
        assign mst_if[k].req_ready = u_req_ready[k];
        assign mst_if[k].rsp_valid = u_rsp_valid[k];
        assign mst_if[k].rsp       = u_rsp[k];
        assign m_req_valid[k]      = mst_if[k].req_valid;
        assign m_rsp_ready[k]      = mst_if[k].rsp_ready;
        assign m_req_id[k]         = mst_if[k].req.id;
    end

    xadac_exe_router #(
        .NoMst     (NoMst),
        .Depth     (Depth),
        .OpcodeMap ({7'h2B, 7'h0B})
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .slv   (slv_if),
        .mst   (mst_if)
    );

    logic [6:0] map [NoMst] = '{7'h0B, 7'h2B};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    function automatic int route(input logic [6:0] op);
        for (int k = 0; k < NoMst; k++) begin
            if (op == map[k]) return k;
        end
        return -1;
    endfunction

    typedef struct {
        int dst;
        int id;
    } tag_t;

    tag_t q[$];

    int               md;
    logic             e_rr;
    logic             e_sv;
    logic [NoMst-1:0] e_rv;
    logic [NoMst-1:0] e_sr;
    RspT              e_rsp;
    tag_t             t;

    // Model: what the outputs must be given the outstanding queue.
    always @(negedge clk) begin
        md    = route(slv_if.req.instr[6:0]);
        e_rr  = !rst && q.size() < Depth &&
                (md < 0 || u_req_ready[md]);
        e_rv  = '0;
        if (!rst && slv_if.req_valid && q.size() < Depth && md >= 0)
            e_rv[md] = 1'b1;
        e_sv  = 1'b0;
        e_sr  = '0;
        e_rsp = '0;
        if (!rst && q.size() > 0) begin
            if (q[0].dst < 0) begin
                e_sv     = 1'b1;
                e_rsp.id = IdT'(q[0].id);
            end else begin
                e_sv           = u_rsp_valid[q[0].dst];
                e_rsp          = u_rsp[q[0].dst];
                e_sr[q[0].dst] = slv_if.rsp_ready;
            end
        end
        chk("model req_ready", slv_if.req_ready, e_rr);
        chk("model mst req_valid", m_req_valid, e_rv);
        chk("model rsp_valid", slv_if.rsp_valid, e_sv);
        chk("model mst rsp_ready", m_rsp_ready, e_sr);
        if (e_sv) chk("model rsp", slv_if.rsp, e_rsp);
        if (rst) begin
            q.delete();
        end else begin
            if (e_sv && slv_if.rsp_ready) void'(q.pop_front());
            if (slv_if.req_valid && e_rr) begin
                t.dst = md;
                t.id  = int'(slv_if.req.id);
                q.push_back(t);
            end
        end
    end

    task automatic drive_req(input logic [6:0] op, input int id);
        slv_if.req           = '0;
        slv_if.req.instr     = {25'h0, op};
        slv_if.req.id        = IdT'(id);
        slv_if.req.rs1       = 32'(id * 3);
        slv_if.req_valid     = 1'b1;
    endtask

    task automatic clear_req();
        slv_if.req_valid = 1'b0;
        slv_if.req       = '0;
    endtask

    task automatic send(input logic [6:0] op, input int id,
                        input string name);
        int n = 0;
        drive_req(op, id);
        @(negedge clk);
        while (!slv_if.req_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({name, " accepted"}, slv_if.req_ready, 1'b1);
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic respond(input int k, input int id,
                           input logic [31:0] data, input string name);
        int n = 0;
        logic [NoMst-1:0] oh;
        oh                = '0;
        oh[k]             = 1'b1;
        u_rsp[k]          = '0;
        u_rsp[k].id       = IdT'(id);
        u_rsp[k].rd_write = 1'b1;
        u_rsp[k].rd_data  = data;
        u_rsp_valid[k]    = 1'b1;
        @(negedge clk);
        while (!m_rsp_ready[k] && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({name, " rsp_ready"}, m_rsp_ready, oh);
        chk({name, " slv id"}, slv_if.rsp.id, IdT'(id));
        chk({name, " slv data"}, slv_if.rsp.rd_data, data);
        @(posedge clk);
        #1;
        u_rsp_valid[k] = 1'b0;
        u_rsp[k]       = '0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_req();
        slv_if.rsp_ready = 1'b1;
        for (int k = 0; k < NoMst; k++) begin
            u_req_ready[k] = 1'b1;
            u_rsp_valid[k] = 1'b0;
            u_rsp[k]       = '0;
        end
        rst = 1'b1;

        // 1. reset then idle
        repeat (2) @(negedge clk);
        chk("rst req_ready", slv_if.req_ready, 1'b0);
        chk("rst rsp_valid", slv_if.rsp_valid, 1'b0);
        chk("rst mst req_valid", m_req_valid, 2'b00);
        chk("rst mst rsp_ready", m_rsp_ready, 2'b00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle req_ready", slv_if.req_ready, 1'b1);
        chk("idle rsp_valid", slv_if.rsp_valid, 1'b0);
        chk("idle mst rsp_ready", m_rsp_ready, 2'b00);

        // 2. single routed request to unit 1
        @(posedge clk);
        #1;
        drive_req(7'h2B, 3);
        @(negedge clk);
        chk("t2 mst req_valid", m_req_valid, 2'b10);
        chk("t2 mst1 req id", m_req_id[1], 4'd3);
        @(posedge clk);
        #1;
        clear_req();
        @(negedge clk);
        chk("t2 waiting rsp_valid", slv_if.rsp_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        u_rsp[1]          = '0;
        u_rsp[1].id       = 4'd3;
        u_rsp[1].rd_write = 1'b1;
        u_rsp[1].rd_data  = 32'hCAFE_0003;
        u_rsp_valid[1]    = 1'b1;
        @(negedge clk);
        chk("t2 rsp_valid", slv_if.rsp_valid, 1'b1);
        chk("t2 rsp id", slv_if.rsp.id, 4'd3);
        chk("t2 rd_data", slv_if.rsp.rd_data, 32'hCAFE_0003);
        chk("t2 mst rsp_ready", m_rsp_ready, 2'b10);
        @(posedge clk);
        #1;
        u_rsp_valid[1] = 1'b0;
        @(negedge clk);
        chk("t2 empty rsp_valid", slv_if.rsp_valid, 1'b0);
        chk("t2 empty rsp_ready", m_rsp_ready, 2'b00);
        @(posedge clk);
        #1;

        // 3. ordering: unit 1 answers first but waits
        send(7'h0B, 1, "t3a");
        send(7'h2B, 2, "t3b");
        u_rsp[1]          = '0;
        u_rsp[1].id       = 4'd2;
        u_rsp[1].rd_write = 1'b1;
        u_rsp[1].rd_data  = 32'hB2;
        u_rsp_valid[1]    = 1'b1;
        @(negedge clk);
        chk("t3 mst1 held", m_rsp_ready[1], 1'b0);
        chk("t3 slv rsp_valid", slv_if.rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        respond(0, 1, 32'hA1, "t3 first");
        respond(1, 2, 32'hB2, "t3 second");

        // 4. unmatched opcode gets a null reply
        drive_req(7'h33, 5);
        @(negedge clk);
        chk("t4 no mst req_valid", m_req_valid, 2'b00);
        chk("t4 req_ready", slv_if.req_ready, 1'b1);
        @(posedge clk);
        #1;
        clear_req();
        @(negedge clk);
        chk("t4 rsp_valid", slv_if.rsp_valid, 1'b1);
        chk("t4 rsp id", slv_if.rsp.id, 4'd5);
        chk("t4 rd_write", slv_if.rsp.rd_write, 1'b0);
        chk("t4 vd_write", slv_if.rsp.vd_write, 1'b0);
        chk("t4 rd_data", slv_if.rsp.rd_data, 32'h0);
        @(posedge clk);
        #1;

        // 5. fill the FIFO, then release one slot
        send(7'h0B, 6, "t5 r0");
        send(7'h2B, 7, "t5 r1");
        send(7'h0B, 8, "t5 r2");
        send(7'h2B, 9, "t5 r3");
        drive_req(7'h0B, 10);
        @(negedge clk);
        chk("t5 full req_ready", slv_if.req_ready, 1'b0);
        chk("t5 full mst req_valid", m_req_valid, 2'b00);
        @(posedge clk);
        #1;
        u_rsp[0]       = '0;
        u_rsp[0].id    = 4'd6;
        u_rsp_valid[0] = 1'b1;
        @(negedge clk);
        chk("t5 pop rsp_valid", slv_if.rsp_valid, 1'b1);
        chk("t5 pop rsp id", slv_if.rsp.id, 4'd6);
        chk("t5 req_ready at pop", slv_if.req_ready, 1'b0);
        @(posedge clk);
        #1;
        u_rsp_valid[0] = 1'b0;
        u_rsp[0]       = '0;
        @(negedge clk);
        chk("t5 req_ready after pop", slv_if.req_ready, 1'b1);
        chk("t5 mst req_valid after pop", m_req_valid, 2'b01);
        @(posedge clk);
        #1;
        clear_req();
        respond(1, 7, 32'h77, "t5 d7");
        respond(0, 8, 32'h88, "t5 d8");
        respond(1, 9, 32'h99, "t5 d9");
        respond(0, 10, 32'hAA, "t5 d10");

        // 6. reset with three outstanding
        send(7'h0B, 11, "t6 r0");
        send(7'h2B, 12, "t6 r1");
        send(7'h0B, 13, "t6 r2");
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst req_ready", slv_if.req_ready, 1'b0);
        chk("t6 rst rsp_valid", slv_if.rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        u_rsp[0]       = '0;
        u_rsp[0].id    = 4'd11;
        u_rsp_valid[0] = 1'b1;
        @(negedge clk);
        chk("t6 empty rsp_valid", slv_if.rsp_valid, 1'b0);
        chk("t6 stale held off", m_rsp_ready, 2'b00);
        chk("t6 req_ready", slv_if.req_ready, 1'b1);
        @(posedge clk);
        #1;
        u_rsp_valid[0] = 1'b0;
        u_rsp[0]       = '0;
        drive_req(7'h2B, 14);
        @(negedge clk);
        chk("t6 new mst req_valid", m_req_valid, 2'b10);
        @(posedge clk);
        #1;
        clear_req();
        respond(1, 14, 32'hEE, "t6 new");
        @(negedge clk);
        chk("end rsp_valid", slv_if.rsp_valid, 1'b0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
